// File: rtl/alu_ctrl_pkg.sv
// Shared opcode constants, scheduler state type and opcode classification helpers
// for the ALU request scheduler.
package alu_ctrl_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_ADD  = 3'd0;
  localparam op_t OP_SUB  = 3'd1;
  localparam op_t OP_MUL  = 3'd2;
  localparam op_t OP_GELU = 3'd3;
  localparam op_t OP_CLZ  = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  function automatic logic is_legal_op(op_t op);
    return op <= OP_CLZ;
  endfunction

  function automatic logic is_multicycle_op(op_t op);
    return (op == OP_MUL) || (op == OP_GELU);
  endfunction

endpackage

// File: rtl/alu_req_scheduler_if.sv
// Bundle of the two request ports, the ALU operand/result wires and the tagged
// response channel. slave = scheduler view, master = clients/ALU/consumer view.
interface alu_req_scheduler_if #(
  parameter int DW = 16,
  parameter int IW = 3
);

  logic          req0_valid_i;
  logic          req0_ready_o;
  logic [IW-1:0] req0_inst_i;
  logic [DW-1:0] req0_a_i;
  logic [DW-1:0] req0_b_i;

  logic          req1_valid_i;
  logic          req1_ready_o;
  logic [IW-1:0] req1_inst_i;
  logic [DW-1:0] req1_a_i;
  logic [DW-1:0] req1_b_i;

  logic [IW-1:0] alu_inst_o;
  logic [DW-1:0] alu_a_o;
  logic [DW-1:0] alu_b_o;
  logic [DW-1:0] alu_data_i;

  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [DW-1:0] rsp_data_o;
  logic          rsp_id_o;
  logic          rsp_err_o;

  modport slave (
    input  req0_valid_i, req0_inst_i, req0_a_i, req0_b_i,
    output req0_ready_o,
    input  req1_valid_i, req1_inst_i, req1_a_i, req1_b_i,
    output req1_ready_o,
    output alu_inst_o, alu_a_o, alu_b_o,
    input  alu_data_i,
    output rsp_valid_o, rsp_data_o, rsp_id_o, rsp_err_o,
    input  rsp_ready_i
  );

  modport master (
    output req0_valid_i, req0_inst_i, req0_a_i, req0_b_i,
    input  req0_ready_o,
    output req1_valid_i, req1_inst_i, req1_a_i, req1_b_i,
    input  req1_ready_o,
    input  alu_inst_o, alu_a_o, alu_b_o,
    output alu_data_i,
    input  rsp_valid_o, rsp_data_o, rsp_id_o, rsp_err_o,
    output rsp_ready_i
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The grant is combinational from the valids; the
// last_grant register moves only when the grant is actually accepted.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);

  logic last_grant_q;

  always_comb begin
    // NOTE: default first so every path assigns grant and no latch is inferred.
    grant = 2'b00;
    unique case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // last_grant resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments for registers keep simulation order-independent.
    if (rst_i) begin
      last_grant_q <= 1'b1;
    end else if (accept) begin
      last_grant_q <= grant[1];
    end
  end

endmodule

// File: rtl/alu_req_scheduler.sv
// Round-robin scheduler in front of the shared combinational ALU: IDLE -> EXEC -> RESP.
// Optional feature macro ALU_MULTICYCLE_EN adds WAIT cycles for MUL/GELU.
module alu_req_scheduler
  import alu_ctrl_pkg::*;
#(
  parameter int DW = 16,
  parameter int IW = 3
`ifdef ALU_MULTICYCLE_EN
  ,
  parameter int MC_CYCLES = 2
`endif
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  alu_req_scheduler_if.slave   bus
);

  state_t        state_q, state_d;
  logic [1:0]    valid;
  logic [1:0]    grant;
  logic          accept;
  logic          capture;
  logic          legal;

  logic [IW-1:0] alu_inst_q;
  logic [DW-1:0] alu_a_q;
  logic [DW-1:0] alu_b_q;
  logic          id_q;
  logic [DW-1:0] rsp_data_q;
  logic          rsp_id_q;
  logic          rsp_err_q;

  assign valid  = {bus.req1_valid_i, bus.req0_valid_i};
  assign accept = (state_q == IDLE) && ((valid & grant) != 2'b00);
  assign legal  = is_legal_op(op_t'(alu_inst_q));

  rr_arb2 u_arb (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .valid  (valid),
    .accept (accept),
    .grant  (grant)
  );

`ifdef ALU_MULTICYCLE_EN
  localparam int CW = (MC_CYCLES > 1) ? $clog2(MC_CYCLES) : 1;
  logic [CW-1:0] cnt_q;
  logic          wait_done;

  assign wait_done = (cnt_q == CW'(MC_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (state_q == EXEC) begin
      cnt_q <= '0;
    end else if (state_q == WAIT) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: if (accept) state_d = EXEC;
      EXEC: begin
`ifdef ALU_MULTICYCLE_EN
        if (is_multicycle_op(op_t'(alu_inst_q))) begin
          state_d = WAIT;
        end else begin
          capture = 1'b1;
          state_d = RESP;
        end
`else
        capture = 1'b1;
        state_d = RESP;
`endif
      end
      WAIT: begin
`ifdef ALU_MULTICYCLE_EN
        if (wait_done) begin
          capture = 1'b1;
          state_d = RESP;
        end
`else
        state_d = IDLE;
`endif
      end
      RESP: if (bus.rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      alu_inst_q <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      id_q       <= 1'b0;
      rsp_data_q <= '0;
      rsp_id_q   <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        alu_inst_q <= grant[1] ? bus.req1_inst_i : bus.req0_inst_i;
        alu_a_q    <= grant[1] ? bus.req1_a_i    : bus.req0_a_i;
        alu_b_q    <= grant[1] ? bus.req1_b_i    : bus.req0_b_i;
        id_q       <= grant[1];
      end
      // Illegal opcodes still run through the ALU; their result is discarded here.
      if (capture) begin
        rsp_data_q <= legal ? bus.alu_data_i : '0;
        rsp_err_q  <= ~legal;
        rsp_id_q   <= id_q;
      end
    end
  end

  assign bus.req0_ready_o = (state_q == IDLE) && grant[0];
  assign bus.req1_ready_o = (state_q == IDLE) && grant[1];
  assign bus.alu_inst_o   = alu_inst_q;
  assign bus.alu_a_o      = alu_a_q;
  assign bus.alu_b_o      = alu_b_q;
  assign bus.rsp_valid_o  = (state_q == RESP);
  assign bus.rsp_data_o   = rsp_data_q;
  assign bus.rsp_id_o     = rsp_id_q;
  assign bus.rsp_err_o    = rsp_err_q;

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Directed bench for alu_req_scheduler: vector table of single ops plus hand-written
// contention, backpressure and reset-in-EXEC sequences. Latency counts the accept cycle as 0.
module tb_alu_req_scheduler;
  import alu_ctrl_pkg::*;

`ifdef ALU_MULTICYCLE_EN
  localparam int MC_LAT = 4;
`else
  localparam int MC_LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  alu_req_scheduler_if #(.DW(16), .IW(3)) bus ();

  alu_req_scheduler #(.DW(16), .IW(3)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Stand-in for the external ALU: Q6.10 arithmetic, GELU approximated as a/2.
  function automatic logic [15:0] clz16(logic [15:0] v);
    int n;
    n = 16;
    for (int i = 15; i >= 0; i--) if (v[i] && n == 16) n = 15 - i;
    return 16'(n);
  endfunction

  logic signed [31:0] prod;
  always_comb begin
    prod = $signed(bus.alu_a_o) * $signed(bus.alu_b_o);
    case (bus.alu_inst_o)
      OP_ADD:  bus.alu_data_i = bus.alu_a_o + bus.alu_b_o;
      OP_SUB:  bus.alu_data_i = bus.alu_a_o - bus.alu_b_o;
      OP_MUL:  bus.alu_data_i = prod[25:10];
      OP_GELU: bus.alu_data_i = bus.alu_a_o >> 1;
      OP_CLZ:  bus.alu_data_i = clz16(bus.alu_a_o);
      default: bus.alu_data_i = 16'hDEAD;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    string       name;
    bit          who;
    logic [2:0]  inst;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_data;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[9];

  function automatic vec_t mk(string nm, bit who, logic [2:0] inst, logic [15:0] a,
                              logic [15:0] b, logic [15:0] d, bit err, int lat);
    vec_t v;
    v.name = nm; v.who = who; v.inst = inst; v.a = a; v.b = b;
    v.exp_data = d; v.exp_err = err; v.exp_lat = lat;
    return v;
  endfunction

  task automatic drop_valids();
    bus.req0_valid_i = 1'b0;
    bus.req1_valid_i = 1'b0;
  endtask

  // Called just after a rising edge with the scheduler idle and rsp_ready_i high.
  task automatic run_op(input bit who, input logic [2:0] inst, input logic [15:0] a,
                        input logic [15:0] b, output logic [15:0] d, output logic rid,
                        output logic err, output int lat);
    int w;
    d = '0; rid = 1'b0; err = 1'b0; lat = -1;
    if (who) begin
      bus.req1_valid_i = 1'b1; bus.req1_inst_i = inst; bus.req1_a_i = a; bus.req1_b_i = b;
    end else begin
      bus.req0_valid_i = 1'b1; bus.req0_inst_i = inst; bus.req0_a_i = a; bus.req0_b_i = b;
    end
    w = 0;
    do begin @(negedge clk); w++; end
    while (!(who ? bus.req1_ready_o : bus.req0_ready_o) && w < 20);
    if (!(who ? bus.req1_ready_o : bus.req0_ready_o)) begin
      check("accept_timeout", 32'd0, 32'd1);
      drop_valids();
      return;
    end
    @(posedge clk); #1;
    drop_valids();
    lat = 0;
    do begin @(negedge clk); lat++; end
    while (!bus.rsp_valid_o && lat < 20);
    d = bus.rsp_data_o; rid = bus.rsp_id_o; err = bus.rsp_err_o;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [15:0] d;
    logic        rid, err;
    int          lat, w;
    bit          stable;

    vecs[0] = mk("add0",     1'b0, OP_ADD,  16'h0400, 16'h0C00, 16'h1000, 1'b0, 2);
    vecs[1] = mk("sub1",     1'b1, OP_SUB,  16'h1000, 16'h0400, 16'h0C00, 1'b0, 2);
    vecs[2] = mk("mul0",     1'b0, OP_MUL,  16'h0800, 16'h0600, 16'h0C00, 1'b0, MC_LAT);
    vecs[3] = mk("clz1",     1'b1, OP_CLZ,  16'h0010, 16'h0000, 16'h000B, 1'b0, 2);
    vecs[4] = mk("gelu1",    1'b1, OP_GELU, 16'h0800, 16'h0000, 16'h0400, 1'b0, MC_LAT);
    vecs[5] = mk("addwrap0", 1'b0, OP_ADD,  16'h7C00, 16'h0800, 16'h8400, 1'b0, 2);
    vecs[6] = mk("ill6_1",   1'b1, 3'd6,    16'h1234, 16'h5678, 16'h0000, 1'b1, 2);
    vecs[7] = mk("ill5_0",   1'b0, 3'd5,    16'h0001, 16'h0002, 16'h0000, 1'b1, 2);
    vecs[8] = mk("ill7_1",   1'b1, 3'd7,    16'hFFFF, 16'h0001, 16'h0000, 1'b1, 2);

    drop_valids();
    bus.req0_inst_i = '0; bus.req0_a_i = '0; bus.req0_b_i = '0;
    bus.req1_inst_i = '0; bus.req1_a_i = '0; bus.req1_b_i = '0;
    bus.rsp_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_rsp_valid", bus.rsp_valid_o, 0);
    check("rst_ready",     {bus.req1_ready_o, bus.req0_ready_o}, 0);
    check("rst_alu",       {bus.alu_inst_o, bus.alu_a_o, bus.alu_b_o}, 0);
    check("rst_rsp",       {bus.rsp_data_o, bus.rsp_id_o, bus.rsp_err_o}, 0);

    // Contention right after reset: grants and response ids alternate from req0
    @(posedge clk); #1;
    bus.req0_valid_i = 1'b1; bus.req0_inst_i = OP_ADD; bus.req0_a_i = 16'h0400; bus.req0_b_i = 16'h0400;
    bus.req1_valid_i = 1'b1; bus.req1_inst_i = OP_SUB; bus.req1_a_i = 16'h0400; bus.req1_b_i = 16'h0C00;
    for (int i = 0; i < 4; i++) begin
      w = 0;
      do begin @(negedge clk); w++; end
      while (!(bus.req0_ready_o || bus.req1_ready_o) && w < 20);
      check($sformatf("cont_grant%0d", i), {bus.req1_ready_o, bus.req0_ready_o},
            (i % 2) ? 2'b10 : 2'b01);
      w = 0;
      do begin @(negedge clk); w++; end
      while (!bus.rsp_valid_o && w < 20);
      check($sformatf("cont_id%0d", i), bus.rsp_id_o, i % 2);
      check($sformatf("cont_data%0d", i), bus.rsp_data_o, (i % 2) ? 16'hF800 : 16'h0800);
    end
    drop_valids();
    @(posedge clk); #1;

    // Vector table of single ops
    foreach (vecs[i]) begin
      run_op(vecs[i].who, vecs[i].inst, vecs[i].a, vecs[i].b, d, rid, err, lat);
      check({vecs[i].name, "_data"}, d,   vecs[i].exp_data);
      check({vecs[i].name, "_id"},   rid, vecs[i].who);
      check({vecs[i].name, "_err"},  err, vecs[i].exp_err);
      check({vecs[i].name, "_lat"},  lat, vecs[i].exp_lat);
    end

    // Backpressure: response held 5 cycles, nobody ready meanwhile
    bus.rsp_ready_i  = 1'b0;
    bus.req0_valid_i = 1'b1; bus.req0_inst_i = OP_ADD; bus.req0_a_i = 16'h0100; bus.req0_b_i = 16'h0200;
    w = 0;
    do begin @(negedge clk); w++; end
    while (!bus.req0_ready_o && w < 20);
    check("bp_accept", bus.req0_ready_o, 1);
    @(posedge clk); #1;
    bus.req0_valid_i = 1'b0;
    bus.req1_valid_i = 1'b1; bus.req1_inst_i = OP_ADD; bus.req1_a_i = 16'h0001; bus.req1_b_i = 16'h0001;
    w = 0;
    do begin @(negedge clk); w++; end
    while (!bus.rsp_valid_o && w < 20);
    stable = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      if (!(bus.rsp_valid_o && bus.rsp_data_o == 16'h0300 && !bus.rsp_id_o &&
            !bus.req0_ready_o && !bus.req1_ready_o)) stable = 1'b0;
    end
    check("bp_stable", stable, 1);
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    check("bp_release_ready1", {bus.req1_ready_o, bus.rsp_valid_o}, 2'b10);
    w = 0;
    do begin @(negedge clk); w++; end
    while (!bus.rsp_valid_o && w < 20);
    check("bp_second", {bus.rsp_id_o, bus.rsp_data_o}, {1'b1, 16'h0002});
    drop_valids();
    @(posedge clk); #1;

    // Reset while req0 op is in EXEC; last_grant would otherwise favour req1
    bus.req0_valid_i = 1'b1; bus.req0_inst_i = OP_ADD; bus.req0_a_i = 16'h1111; bus.req0_b_i = 16'h2222;
    w = 0;
    do begin @(negedge clk); w++; end
    while (!bus.req0_ready_o && w < 20);
    @(posedge clk); #1;
    bus.req0_valid_i = 1'b0;
    check("rx_loaded", {bus.alu_a_o, bus.alu_b_o}, {16'h1111, 16'h2222});
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rx_rsp_valid", bus.rsp_valid_o, 0);
    check("rx_alu",       {bus.alu_inst_o, bus.alu_a_o, bus.alu_b_o}, 0);
    bus.req0_valid_i = 1'b1;
    bus.req1_valid_i = 1'b1;
    #1;
    check("rx_grant_req0", {bus.req1_ready_o, bus.req0_ready_o}, 2'b01);
    drop_valids();
    @(posedge clk); #1;
    check("rx_idle", {bus.rsp_valid_o, bus.alu_a_o}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
